// File: rtl/mc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mc_pkg
//  Brief    : Shared encodings for the multi-cycle MIPS controller: FSM
//             states, opcode/funct constants, datapath mux selects and the
//             instruction-class bundle produced by the decoder.
//  Revision : 1.0  initial release
// ============================================================================
package mc_pkg;

  // FSM states; the code values are visible on the debug state port
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  // Primary opcodes (IR[31:26])
  localparam logic [5:0] c_OP_RTYPE = 6'b000000;
  localparam logic [5:0] c_OP_ORI   = 6'b001101;
  localparam logic [5:0] c_OP_ADDI  = 6'b001000;
  localparam logic [5:0] c_OP_LW    = 6'b100011;
  localparam logic [5:0] c_OP_LB    = 6'b100000;
  localparam logic [5:0] c_OP_SW    = 6'b101011;
  localparam logic [5:0] c_OP_BEQ   = 6'b000100;
  localparam logic [5:0] c_OP_BGTZ  = 6'b000111;
  localparam logic [5:0] c_OP_LUI   = 6'b001111;
  localparam logic [5:0] c_OP_J     = 6'b000010;
  localparam logic [5:0] c_OP_JAL   = 6'b000011;

  // R-type function codes (IR[5:0])
  localparam logic [5:0] c_FN_ADD  = 6'b100000;
  localparam logic [5:0] c_FN_SUB  = 6'b100010;
  localparam logic [5:0] c_FN_SLL  = 6'b000000;
  localparam logic [5:0] c_FN_JR   = 6'b001000;
  localparam logic [5:0] c_FN_JALR = 6'b001001;

  // ALU operation select
  localparam logic [2:0] c_ALU_ADD   = 3'd0;
  localparam logic [2:0] c_ALU_SUB   = 3'd1;
  localparam logic [2:0] c_ALU_OR    = 3'd2;
  localparam logic [2:0] c_ALU_SLL   = 3'd3;
  localparam logic [2:0] c_ALU_PASSB = 3'd4;

  // Immediate extender mode
  localparam logic [1:0] c_EXT_ZERO = 2'd0;
  localparam logic [1:0] c_EXT_SIGN = 2'd1;
  localparam logic [1:0] c_EXT_LUI  = 2'd2;

  // GRF write-address select
  localparam logic [1:0] c_DST_RT = 2'd0;
  localparam logic [1:0] c_DST_RD = 2'd1;
  localparam logic [1:0] c_DST_RA = 2'd2;

  // GRF write-data select
  localparam logic [1:0] c_M2R_ALU  = 2'd0;
  localparam logic [1:0] c_M2R_WORD = 2'd1;
  localparam logic [1:0] c_M2R_BYTE = 2'd2;
  localparam logic [1:0] c_M2R_PC4  = 2'd3;

  // Next-PC select
  localparam logic [1:0] c_NPC_PC4 = 2'd0;
  localparam logic [1:0] c_NPC_BR  = 2'd1;
  localparam logic [1:0] c_NPC_J   = 2'd2;
  localparam logic [1:0] c_NPC_REG = 2'd3;

  // One-hot instruction classes; at most one bit is set for a legal encoding
  typedef struct packed {
    logic add;
    logic sub;
    logic sll;
    logic jr;
    logic jalr;
    logic ori;
    logic addi;
    logic lui;
    logic lw;
    logic lb;
    logic sw;
    logic beq;
    logic bgtz;
    logic j;
    logic jal;
  } iclass_t;

  // Instructions that compute in the ALU and write the result back
  function automatic logic f_is_alu(input iclass_t c);
    return c.add | c.sub | c.sll | c.ori | c.addi | c.lui;
  endfunction

endpackage : mc_pkg
`default_nettype wire

// File: rtl/mc_if.sv
`default_nettype none
// ============================================================================
//  Module   : mc_if
//  Brief    : Bundle between the multi-cycle controller and the datapath:
//             IR fields and condition flags in, enables and mux selects out.
//  Revision : 1.0  initial release
// ============================================================================
interface mc_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       gtz;
  logic       mem_ready;

  logic       pc_write;
  logic       ir_write;
  logic       reg_write;
  logic       mem_read;
  logic       mem_write;
  logic [2:0] alu_control;
  logic       alu_src;
  logic [1:0] ext_op;
  logic [1:0] reg_dst;
  logic [1:0] mem2reg;
  logic [1:0] npc_sel;
  logic       illegal;
  logic       retire;
  logic [2:0] state;

  // Controller side
  modport master (
    input  opcode, funct, zero, gtz, mem_ready,
    output pc_write, ir_write, reg_write, mem_read, mem_write,
           alu_control, alu_src, ext_op, reg_dst, mem2reg, npc_sel,
           illegal, retire, state
  );

  // Datapath side
  modport slave (
    output opcode, funct, zero, gtz, mem_ready,
    input  pc_write, ir_write, reg_write, mem_read, mem_write,
           alu_control, alu_src, ext_op, reg_dst, mem2reg, npc_sel,
           illegal, retire, state
  );
endinterface : mc_if
`default_nettype wire

// File: rtl/mc_decode.sv
`default_nettype none
// ============================================================================
//  Module   : mc_decode
//  Brief    : Pure combinational opcode/funct decoder producing one-hot
//             instruction classes and an illegal-encoding flag.
//  Revision : 1.0  initial release
// ============================================================================
module mc_decode
  import mc_pkg::*;
(
  input  wire logic [5:0] i_opcode,
  input  wire logic [5:0] i_funct,
  output iclass_t         o_class,
  output logic            o_illegal
);

  // funct only matters for R-type; everything else decodes on opcode alone
  always_comb begin
    o_class = '0;
    if (i_opcode == c_OP_RTYPE) begin
      case (i_funct)
        c_FN_ADD:  o_class.add  = 1'b1;
        c_FN_SUB:  o_class.sub  = 1'b1;
        c_FN_SLL:  o_class.sll  = 1'b1;
        c_FN_JR:   o_class.jr   = 1'b1;
        c_FN_JALR: o_class.jalr = 1'b1;
        default:   o_class      = '0;
      endcase
    end else begin
      case (i_opcode)
        c_OP_ORI:  o_class.ori  = 1'b1;
        c_OP_ADDI: o_class.addi = 1'b1;
        c_OP_LW:   o_class.lw   = 1'b1;
        c_OP_LB:   o_class.lb   = 1'b1;
        c_OP_SW:   o_class.sw   = 1'b1;
        c_OP_BEQ:  o_class.beq  = 1'b1;
        c_OP_BGTZ: o_class.bgtz = 1'b1;
        c_OP_LUI:  o_class.lui  = 1'b1;
        c_OP_J:    o_class.j    = 1'b1;
        c_OP_JAL:  o_class.jal  = 1'b1;
        default:   o_class      = '0;
      endcase
    end
  end

  assign o_illegal = (o_class == '0);

endmodule : mc_decode
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_ctrl
//  Brief    : Multi-cycle control FSM for the MIPS datapath. The state is the
//             only register; all controls are decoded from the state, the IR
//             fields and the condition inputs. Data-memory accesses wait on
//             mem_ready.
//  Revision : 1.0  initial release
// ============================================================================
module multicycle_ctrl (
  input  wire logic clk,
  input  wire logic reset,
  mc_if.master      bus
);
  import mc_pkg::*;

  state_t     r_state;
  state_t     w_next;
  iclass_t    w_cls;
  logic       w_illegal_enc;
  logic       w_is_alu;
  logic       w_is_load;
  logic       w_is_mem;

  // Class-dependent ALU/extender setup
  logic [2:0] w_cls_alu;
  logic       w_cls_src;
  logic [1:0] w_cls_ext;

  // Unmasked strobes and selects from the state decode
  logic       w_pc_write;
  logic       w_ir_write;
  logic       w_reg_write;
  logic       w_mem_read;
  logic       w_mem_write;
  logic       w_illegal;
  logic       w_retire;
  logic [2:0] w_alu;
  logic       w_src;
  logic [1:0] w_ext;
  logic [1:0] w_dst;
  logic [1:0] w_m2r;
  logic [1:0] w_npc;

  mc_decode u_decode (
    .i_opcode  (bus.opcode),
    .i_funct   (bus.funct),
    .o_class   (w_cls),
    .o_illegal (w_illegal_enc)
  );

  assign w_is_alu  = f_is_alu(w_cls);
  assign w_is_load = w_cls.lw | w_cls.lb;
  assign w_is_mem  = w_is_load | w_cls.sw;

  // ALU operation, B-operand source and extender mode for each class
  always_comb begin
    w_cls_alu = c_ALU_ADD;
    w_cls_src = 1'b0;
    w_cls_ext = c_EXT_ZERO;
    if (w_cls.sub | w_cls.beq) begin
      w_cls_alu = c_ALU_SUB;
    end else if (w_cls.sll) begin
      w_cls_alu = c_ALU_SLL;
    end else if (w_cls.ori) begin
      w_cls_alu = c_ALU_OR;
      w_cls_src = 1'b1;
    end else if (w_cls.addi | w_is_mem) begin
      w_cls_alu = c_ALU_ADD;
      w_cls_src = 1'b1;
      w_cls_ext = c_EXT_SIGN;
    end else if (w_cls.lui) begin
      w_cls_alu = c_ALU_PASSB;
      w_cls_src = 1'b1;
      w_cls_ext = c_EXT_LUI;
    end
  end

  // Next state and per-state controls; ALU setup is held from EXEC through
  // MEM/WB because the datapath has no ALU output register
  always_comb begin
    w_next      = S_FETCH;
    w_pc_write  = 1'b0;
    w_ir_write  = 1'b0;
    w_reg_write = 1'b0;
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    w_illegal   = 1'b0;
    w_retire    = 1'b0;
    w_alu       = c_ALU_ADD;
    w_src       = 1'b0;
    w_ext       = c_EXT_ZERO;
    w_dst       = c_DST_RT;
    w_m2r       = c_M2R_ALU;
    w_npc       = c_NPC_PC4;

    case (r_state)
      S_FETCH: begin
        w_ir_write = 1'b1;
        w_pc_write = 1'b1;
        w_npc      = c_NPC_PC4;
        w_next     = S_DECODE;
      end

      S_DECODE: begin
        if (w_illegal_enc) begin
          w_illegal = 1'b1;
          w_retire  = 1'b1;
          w_next    = S_FETCH;
        end else if (w_cls.j) begin
          w_pc_write = 1'b1;
          w_npc      = c_NPC_J;
          w_retire   = 1'b1;
          w_next     = S_FETCH;
        end else if (w_cls.jr) begin
          w_pc_write = 1'b1;
          w_npc      = c_NPC_REG;
          w_retire   = 1'b1;
          w_next     = S_FETCH;
        end else if (w_cls.jal | w_cls.jalr) begin
          w_next = S_WB;
        end else begin
          w_next = S_EXEC;
        end
      end

      S_EXEC: begin
        w_alu = w_cls_alu;
        w_src = w_cls_src;
        w_ext = w_cls_ext;
        if (w_is_mem) begin
          w_next = S_MEM;
        end else if (w_cls.beq) begin
          w_pc_write = bus.zero;
          w_npc      = c_NPC_BR;
          w_retire   = 1'b1;
          w_next     = S_FETCH;
        end else if (w_cls.bgtz) begin
          w_pc_write = bus.gtz;
          w_npc      = c_NPC_BR;
          w_retire   = 1'b1;
          w_next     = S_FETCH;
        end else if (w_is_alu) begin
          w_next = S_WB;
        end else begin
          // IR no longer holds an EXEC-class instruction; abandon it
          w_retire = 1'b1;
          w_next   = S_FETCH;
        end
      end

      S_MEM: begin
        w_alu       = w_cls_alu;
        w_src       = w_cls_src;
        w_ext       = w_cls_ext;
        w_mem_read  = w_is_load;
        w_mem_write = w_cls.sw;
        if (!w_is_mem) begin
          w_retire = 1'b1;
          w_next   = S_FETCH;
        end else if (!bus.mem_ready) begin
          w_next = S_MEM;
        end else if (w_cls.sw) begin
          w_retire = 1'b1;
          w_next   = S_FETCH;
        end else begin
          w_next = S_WB;
        end
      end

      S_WB: begin
        w_reg_write = 1'b1;
        w_retire    = 1'b1;
        w_next      = S_FETCH;
        if (w_cls.jal) begin
          w_dst      = c_DST_RA;
          w_m2r      = c_M2R_PC4;
          w_pc_write = 1'b1;
          w_npc      = c_NPC_J;
        end else if (w_cls.jalr) begin
          w_dst      = c_DST_RD;
          w_m2r      = c_M2R_PC4;
          w_pc_write = 1'b1;
          w_npc      = c_NPC_REG;
        end else if (w_is_load) begin
          w_dst = c_DST_RT;
          w_m2r = w_cls.lb ? c_M2R_BYTE : c_M2R_WORD;
        end else begin
          w_alu = w_cls_alu;
          w_src = w_cls_src;
          w_ext = w_cls_ext;
          w_dst = (w_cls.add | w_cls.sub | w_cls.sll) ? c_DST_RD : c_DST_RT;
          w_m2r = c_M2R_ALU;
        end
      end

      // Unused codes recover to FETCH with no writes and nothing retired
      default: begin
        w_next = S_FETCH;
      end
    endcase
  end

  // State register; reset restarts at FETCH and abandons any access
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Strobes are suppressed during reset; selects are harmless and pass through
  assign bus.pc_write    = w_pc_write  & ~reset;
  assign bus.ir_write    = w_ir_write  & ~reset;
  assign bus.reg_write   = w_reg_write & ~reset;
  assign bus.mem_read    = w_mem_read  & ~reset;
  assign bus.mem_write   = w_mem_write & ~reset;
  assign bus.illegal     = w_illegal   & ~reset;
  assign bus.retire      = w_retire    & ~reset;
  assign bus.alu_control = w_alu;
  assign bus.alu_src     = w_src;
  assign bus.ext_op      = w_ext;
  assign bus.reg_dst     = w_dst;
  assign bus.mem2reg     = w_m2r;
  assign bus.npc_sel     = w_npc;
  assign bus.state       = r_state;

endmodule : multicycle_ctrl
`default_nettype wire

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle control FSM for the MIPS CPU: it sequences the shared datapath (PC, IR, GRF, EXT, ALU, NPC, DM) over several cycles per instruction, replacing the single-cycle decoder. Data-memory accesses use a ready handshake so DM may take a variable number of cycles. The block sits between the IR register and the datapath mux/enable inputs.

## Interface
Parameters:
- none; all encodings are fixed constants in the shared package.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high; one clock domain only
- opcode  in  6  IR[31:26], valid from DECODE onward
- funct  in  6  IR[5:0]
- zero  in  1  ALU A==B, from the EXEC-cycle compare
- gtz  in  1  signed GRF[rs] > 0
- mem_ready  in  1  DM completes the current access this cycle
- pc_write  out  1  PC load enable
- ir_write  out  1  IR load enable
- reg_write  out  1  GRF write enable
- mem_read  out  1  DM read request
- mem_write  out  1  DM write request
- alu_control  out  3  0 ADD, 1 SUB, 2 OR, 3 SLL, 4 PASSB
- alu_src  out  1  0 GRF[rt], 1 EXT output
- ext_op  out  2  0 zero-ext, 1 sign-ext, 2 imm<<16
- reg_dst  out  2  0 rt, 1 rd, 2 $31
- mem2reg  out  2  0 ALU result, 1 DM word, 2 DM byte sign-ext, 3 PC+4
- npc_sel  out  2  0 PC+4, 1 branch, 2 imm26 jump, 3 GRF[rs]
- illegal  out  1  one-cycle pulse in DECODE for an unsupported encoding
- retire  out  1  one-cycle pulse in the last state of each instruction
- state  out  3  current state, for debug

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4. `state` is the only register. All outputs are combinational from `state`, `opcode`, `funct` and the condition inputs.
- Decoding uses opcode only, except for R-type (opcode 000000), which also uses funct. R-type: add 100000, sub 100010, sll 000000, jr 001000, jalr 001001. I/J-type: ori 001101, addi 001000, lw 100011, lb 100000, sw 101011, beq 000100, bgtz 000111, lui 001111, j 000010, jal 000011.
- FETCH: ir_write=1, pc_write=1, npc_sel=0. Next state is DECODE.
- DECODE:
  - j: pc_write=1, npc_sel=2, then FETCH.
  - jr: pc_write=1, npc_sel=3, then FETCH.
  - jal/jalr: go to WB.
  - illegal encoding: illegal=1, no writes, then FETCH.
  - all others: go to EXEC.
- EXEC:
  - ALU classes: go to WB.
  - lw/lb/sw: alu ADD with sign-extended immediate, then MEM.
  - beq: pc_write=zero, npc_sel=1, then FETCH.
  - bgtz: pc_write=gtz, npc_sel=1, then FETCH.
- MEM: mem_read (lw/lb) or mem_write (sw) is held high until mem_ready.
  - If mem_ready=0, stay in MEM.
  - If mem_ready=1: loads go to WB, sw goes to FETCH.
- WB: reg_write=1, then FETCH. jal: reg_dst=2, mem2reg=3, pc_write=1, npc_sel=2. jalr: reg_dst=1, mem2reg=3, pc_write=1, npc_sel=3.
- Per-class controls:
  - add/sub/sll: reg_dst=1, alu_src=0.
  - ori: ext 0, OR.
  - addi: ext 1, ADD.
  - lui: ext 2, PASSB.
  - loads: reg_dst=0. lw uses mem2reg=1, lb uses mem2reg=2.
- Idle defaults: all enables and requests 0, all selects 0.
- retire=1 on the transition into FETCH from any state other than FETCH, including illegal.

## Timing
- Cycle counts with mem_ready immediate:
  - j, jr, illegal: 2 cycles
  - beq, bgtz, jal, jalr: 3 cycles
  - ALU instructions: 4 cycles
  - sw: 4 cycles
  - lw, lb: 5 cycles
  - each mem_ready=0 cycle in MEM adds one cycle.
- mem_read/mem_write are stable and never deasserted while mem_ready=0. mem_ready outside MEM is ignored.
- Reset:
  - While reset=1, pc_write, ir_write, reg_write, mem_read, mem_write, illegal and retire are all forced to 0, whatever the state.
  - The next state is FETCH.
  - Reset in MEM abandons the access; no write follows.
  - After reset: state=0, and all outputs are 0 except the FETCH strobes, which assert in the first cycle after reset deasserts.
- An unreachable state code (5–7) goes to FETCH with no writes.

## Structure
- Package `mc_pkg`: state enum, opcode/funct constants, and the alu_control/ext_op/reg_dst/mem2reg/npc_sel encodings, shared with the datapath muxes.
- Optional sub-module `mc_decode`: pure opcode/funct → instruction-class one-hots plus illegal flag. The FSM consumes these classes.

## Test plan
- ori then add, mem_ready tied 1:
  - state sequence 0,1,2,4,0 for each instruction
  - reg_write only in WB, with reg_dst 0 then 1
  - retire twice in 8 cycles.
- lw with mem_ready low for 3 cycles:
  - MEM held for 4 cycles with mem_read=1 throughout
  - WB with mem2reg=1; total 8 cycles.
- beq with zero=1, then beq with zero=0:
  - first: pc_write=1, npc_sel=1 in EXEC
  - second: pc_write=0 in EXEC
  - each instruction takes 3 cycles.
- jal, then jalr:
  - jal: WB with reg_dst=2, mem2reg=3, npc_sel=2
  - jalr: WB with reg_dst=1, npc_sel=3.
- Opcode 111111:
  - illegal pulses in DECODE, no writes, returns to FETCH
  - retire=1.
- sw with mem_ready=0, reset asserted on the 2nd MEM cycle:
  - mem_write=0 while reset is high
  - state=0 on the next cycle; no WB occurs.
